// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard/stall scheduler for the 5-stage MIPS pipeline. Compares the decode
// stage source registers against the EX and MEM destinations. It drives the
// stall and flush controls for the PC, IF/ID and ID/EX. It also sequences the
// two-cycle load-to-branch stall and the wait for the mult/div unit.
//
// Parameters
//   CNT_W          width of the saturating stall-cycle counter
//   MD_MAX_CYCLES  cycles allowed in the mult/div wait before a timeout
//
// Ports
//   CLK, RESET     rising-edge clock, synchronous active-high reset
//   RsD, RtD       decode source register fields
//   UsesRtD        decode instruction reads rt
//   BranchD        decode instruction is beq/bne (compared in decode)
//   PCSrcD         branch/jump resolved taken in decode
//   MulDivStartD   decode instruction is mult/multu/div/divu
//   HiLoReadD      decode instruction is mfhi/mflo
//   RegWriteE, MemToRegE, WriteRegE   EX stage write-back info
//   RegWriteM, MemToRegM, WriteRegM   MEM stage write-back info
//   MulDivDone     one-cycle pulse, the mult/div unit has finished
//   StallF/StallD  hold PC / IF/ID
//   FlushD/FlushE  clear IF/ID / inject a bubble into ID/EX
//   MdTimeout      sticky error, the mult/div wait hit its limit
//   StallCycles    count of cycles with StallD=1, saturating
// ---------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int CNT_W         = 16,
   parameter int MD_MAX_CYCLES = 64
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [4:0]       RsD,
   input  logic [4:0]       RtD,
   input  logic             UsesRtD,
   input  logic             BranchD,
   input  logic             PCSrcD,
   input  logic             MulDivStartD,
   input  logic             HiLoReadD,
   input  logic             RegWriteE,
   input  logic             MemToRegE,
   input  logic [4:0]       WriteRegE,
   input  logic             RegWriteM,
   input  logic             MemToRegM,
   input  logic [4:0]       WriteRegM,
   input  logic             MulDivDone,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic             MdTimeout,
   output logic [CNT_W-1:0] StallCycles
);

   localparam int MD_W = (MD_MAX_CYCLES > 1) ? $clog2(MD_MAX_CYCLES) : 1;
   localparam logic [MD_W-1:0]  MD_LAST = MD_W'(MD_MAX_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      STALL2 = 2'd1,
      MDWAIT = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [MD_W-1:0]  md_cnt_r;
   logic [MD_W-1:0]  md_cnt_nxt_s;
   logic             md_timeout_r;
   logic             timeout_set_s;
   logic [CNT_W-1:0] stall_cnt_r;
   logic             stall_s;
   logic             flushd_s;
   logic             lu_s;
   logic             br_alu_s;
   logic             br_ld_m_s;
   logic [1:0]       need_s;

   // A destination register hazards the decode instruction when it is a real
   // source of it; $0 is hard-wired and never hazards.
   function automatic logic reg_match(
      input logic [4:0] dst,
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic       uses_rt
   );
      return (dst != 5'd0) && ((dst == rs) || (uses_rt && (dst == rt)));
   endfunction

   assign lu_s      = MemToRegE & RegWriteE & reg_match(WriteRegE, RsD, RtD, UsesRtD);
   assign br_alu_s  = BranchD & RegWriteE & ~MemToRegE & reg_match(WriteRegE, RsD, RtD, UsesRtD);
   assign br_ld_m_s = BranchD & MemToRegM & RegWriteM & reg_match(WriteRegM, RsD, RtD, UsesRtD);

   // Stall need: a load feeding a branch needs the load to reach WB, which
   // takes two bubbles; every other hazard is resolved by one bubble.
   always_comb begin
      need_s = 2'd0;
      if (lu_s && BranchD) begin
         need_s = 2'd2;
      end else if (lu_s || br_alu_s || br_ld_m_s) begin
         need_s = 2'd1;
      end else begin
         need_s = 2'd0;
      end
   end

   // Next-state and control outputs; all outputs are same-cycle combinational.
   always_comb begin
      state_nxt_s   = state_r;
      md_cnt_nxt_s  = md_cnt_r;
      timeout_set_s = 1'b0;
      stall_s       = 1'b0;
      flushd_s      = 1'b0;
      if (RESET) begin
         state_nxt_s  = RUN;
         md_cnt_nxt_s = {MD_W{1'b0}};
      end else begin
         case (state_r)
            RUN: begin
               if (need_s != 2'd0) begin
                  stall_s = 1'b1;
                  if (need_s == 2'd2) begin
                     state_nxt_s = STALL2;
                  end else begin
                     state_nxt_s = RUN;
                  end
               end else begin
                  flushd_s = PCSrcD;
                  if (MulDivStartD) begin
                     state_nxt_s  = MDWAIT;
                     md_cnt_nxt_s = {MD_W{1'b0}};
                  end else begin
                     state_nxt_s = RUN;
                  end
               end
            end
            STALL2: begin
               // Second bubble of a load-to-branch stall; a taken branch
               // cannot be acted on while the branch itself is held.
               stall_s     = 1'b1;
               state_nxt_s = RUN;
            end
            MDWAIT: begin
               // HI/LO consumers and a second mult/div wait for the unit.
               // Other hazards get one bubble at a time and are re-evaluated,
               // so a load-to-branch never enters STALL2 from here.
               if (HiLoReadD || MulDivStartD) begin
                  stall_s = 1'b1;
               end else if (need_s != 2'd0) begin
                  stall_s = 1'b1;
               end else begin
                  flushd_s = PCSrcD;
               end
               if (MulDivDone) begin
                  state_nxt_s = RUN;
               end else if (md_cnt_r == MD_LAST) begin
                  timeout_set_s = 1'b1;
                  state_nxt_s   = RUN;
               end else begin
                  md_cnt_nxt_s = md_cnt_r + MD_W'(1);
               end
            end
            default: begin
               state_nxt_s = RUN;
            end
         endcase
      end
   end

   // State, mult/div wait counter, sticky timeout and stall counter.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r      <= RUN;
         md_cnt_r     <= {MD_W{1'b0}};
         md_timeout_r <= 1'b0;
         stall_cnt_r  <= {CNT_W{1'b0}};
      end else begin
         state_r  <= state_nxt_s;
         md_cnt_r <= md_cnt_nxt_s;
         if (timeout_set_s) begin
            md_timeout_r <= 1'b1;
         end
         if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
         end
      end
   end

   assign StallF      = stall_s;
   assign StallD      = stall_s;
   assign FlushE      = stall_s;
   assign FlushD      = flushd_s;
   assign MdTimeout   = md_timeout_r;
   assign StallCycles = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed test of hazard_ctrl. A behavioural model follows the pipeline
// rules from cycle to cycle. It is compared with every DUT output on each
// falling edge. Literal expectations pin the key points of each scenario.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int CNT_W  = 16;
   localparam int MD_MAX = 64;

   logic             CLK = 1'b0;
   logic             RESET;
   logic [4:0]       RsD, RtD, WriteRegE, WriteRegM;
   logic             UsesRtD, BranchD, PCSrcD, MulDivStartD, HiLoReadD;
   logic             RegWriteE, MemToRegE, RegWriteM, MemToRegM, MulDivDone;
   logic             StallF, StallD, FlushD, FlushE, MdTimeout;
   logic [CNT_W-1:0] StallCycles;

   int nvec = 0;
   int nerr = 0;

   hazard_ctrl #(.CNT_W(CNT_W), .MD_MAX_CYCLES(MD_MAX)) dut (
      .CLK(CLK), .RESET(RESET), .RsD(RsD), .RtD(RtD), .UsesRtD(UsesRtD),
      .BranchD(BranchD), .PCSrcD(PCSrcD), .MulDivStartD(MulDivStartD),
      .HiLoReadD(HiLoReadD), .RegWriteE(RegWriteE), .MemToRegE(MemToRegE),
      .WriteRegE(WriteRegE), .RegWriteM(RegWriteM), .MemToRegM(MemToRegM),
      .WriteRegM(WriteRegM), .MulDivDone(MulDivDone), .StallF(StallF),
      .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .MdTimeout(MdTimeout), .StallCycles(StallCycles)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic bit hz(input logic [4:0] w);
      return (w != 5'd0) && ((w == RsD) || (UsesRtD && (w == RtD)));
   endfunction

   // Bubbles the current decode instruction needs from register hazards.
   function automatic int need_level();
      int n = 0;
      if (MemToRegE && RegWriteE && hz(WriteRegE)) n = BranchD ? 2 : 1;
      if (n < 1 && BranchD && RegWriteE && !MemToRegE && hz(WriteRegE)) n = 1;
      if (n < 1 && BranchD && MemToRegM && RegWriteM && hz(WriteRegM)) n = 1;
      return n;
   endfunction

   bit     m_extra = 1'b0;   // a second load-to-branch bubble is owed
   bit     m_wait  = 1'b0;   // a mult/div is in flight
   int     m_start = 0;      // cycle the mult/div was in decode
   bit     m_to    = 1'b0;
   longint m_cnt   = 0;
   int     cyc     = 0;

   initial begin
      @(posedge CLK);
      forever begin
         @(negedge CLK);
         begin
            int n;
            bit e_stall;
            bit e_fd;
            n       = need_level();
            e_stall = 1'b0;
            e_fd    = 1'b0;
            if (RESET) begin
               e_stall = 1'b0;
            end else if (m_extra) begin
               e_stall = 1'b1;
            end else if (m_wait && (HiLoReadD || MulDivStartD)) begin
               e_stall = 1'b1;
            end else if (n > 0) begin
               e_stall = 1'b1;
            end else begin
               e_fd = PCSrcD;
            end
            chk("model_StallF", 32'(StallF), 32'(e_stall));
            chk("model_StallD", 32'(StallD), 32'(e_stall));
            chk("model_FlushE", 32'(FlushE), 32'(e_stall));
            chk("model_FlushD", 32'(FlushD), 32'(e_fd));
            chk("model_MdTimeout", 32'(MdTimeout), 32'(m_to));
            chk("model_StallCycles", 32'(StallCycles), 32'(m_cnt));
            // advance to what the next cycle must look like
            if (RESET) begin
               m_extra = 1'b0;
               m_wait  = 1'b0;
               m_to    = 1'b0;
               m_cnt   = 0;
            end else begin
               if (e_stall && m_cnt < (64'd1 << CNT_W) - 1) m_cnt++;
               if (m_extra) begin
                  m_extra = 1'b0;
               end else if (m_wait) begin
                  if (MulDivDone) begin
                     m_wait = 1'b0;
                  end else if (cyc - m_start == MD_MAX) begin
                     m_wait = 1'b0;
                     m_to   = 1'b1;
                  end
               end else if (n == 2) begin
                  m_extra = 1'b1;
               end else if (n == 0 && MulDivStartD) begin
                  m_wait  = 1'b1;
                  m_start = cyc;
               end
            end
            cyc++;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic clr_in();
      RsD = 5'd0; RtD = 5'd0; UsesRtD = 1'b0; BranchD = 1'b0; PCSrcD = 1'b0;
      MulDivStartD = 1'b0; HiLoReadD = 1'b0; RegWriteE = 1'b0; MemToRegE = 1'b0;
      WriteRegE = 5'd0; RegWriteM = 1'b0; MemToRegM = 1'b0; WriteRegM = 5'd0;
      MulDivDone = 1'b0;
   endtask

   task automatic next();
      @(posedge CLK);
      #1;
      clr_in();
   endtask

   initial begin
      RESET = 1'b1;
      clr_in();
      MemToRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd2; RsD = 5'd2;
      next();
      MemToRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd2; RsD = 5'd2; PCSrcD = 1'b1;
      #2 chk("lit_rst_stall", 32'(StallD), 32'd0);
      chk("lit_rst_flush", 32'(FlushD), 32'd0);
      next();
      RESET = 1'b0;
      #2 chk("lit_rst_cnt", 32'(StallCycles), 32'd0);
      chk("lit_rst_to", 32'(MdTimeout), 32'd0);

      // 1: load-use, non-branch -> single bubble
      next(); MemToRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd2; RsD = 5'd2;
      #2 chk("lit_t1_stallf", 32'(StallF), 32'd1);
      chk("lit_t1_flushe", 32'(FlushE), 32'd1);
      chk("lit_t1_flushd", 32'(FlushD), 32'd0);
      next(); MemToRegM = 1'b1; RegWriteM = 1'b1; WriteRegM = 5'd2; RsD = 5'd2;
      #2 chk("lit_t1_release", 32'(StallD), 32'd0);
      chk("lit_t1_cnt", 32'(StallCycles), 32'd1);

      // 2: load feeding beq -> two bubbles, taken flag ignored while held
      next(); MemToRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd3;
      BranchD = 1'b1; RtD = 5'd3; UsesRtD = 1'b1; RsD = 5'd4;
      #2 chk("lit_t2_stall1", 32'(StallD), 32'd1);
      next(); MemToRegM = 1'b1; RegWriteM = 1'b1; WriteRegM = 5'd3;
      BranchD = 1'b1; RtD = 5'd3; UsesRtD = 1'b1; RsD = 5'd4; PCSrcD = 1'b1;
      #2 chk("lit_t2_stall2", 32'(StallD), 32'd1);
      chk("lit_t2_noflush", 32'(FlushD), 32'd0);
      next(); BranchD = 1'b1; RtD = 5'd3; UsesRtD = 1'b1; PCSrcD = 1'b1;
      #2 chk("lit_t2_go", 32'(StallD), 32'd0);
      chk("lit_t2_flush", 32'(FlushD), 32'd1);
      chk("lit_t2_cnt", 32'(StallCycles), 32'd3);
      next();
      #2 chk("lit_t2_flush_end", 32'(FlushD), 32'd0);

      // 3: $0 never hazards; ALU result into branch; MEM load into branch
      next(); MemToRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd0;
      RsD = 5'd0; RtD = 5'd0; UsesRtD = 1'b1; BranchD = 1'b1;
      #2 chk("lit_t3_r0", 32'(StallD), 32'd0);
      next(); RegWriteE = 1'b1; WriteRegE = 5'd5; BranchD = 1'b1; RsD = 5'd5;
      #2 chk("lit_t3_alu_br", 32'(StallD), 32'd1);
      next(); RegWriteM = 1'b1; WriteRegM = 5'd5; BranchD = 1'b1; RsD = 5'd5;
      #2 chk("lit_t3_alu_m", 32'(StallD), 32'd0);
      next(); RegWriteE = 1'b1; WriteRegE = 5'd7; RsD = 5'd7;
      #2 chk("lit_t3_alu_nobr", 32'(StallD), 32'd0);
      next(); MemToRegM = 1'b1; RegWriteM = 1'b1; WriteRegM = 5'd9;
      RtD = 5'd9; UsesRtD = 1'b1; BranchD = 1'b1;
      #2 chk("lit_t3_ld_m_br", 32'(StallD), 32'd1);
      next(); MemToRegM = 1'b1; RegWriteM = 1'b1; WriteRegM = 5'd9;
      RtD = 5'd9; UsesRtD = 1'b0; BranchD = 1'b1;
      #2 chk("lit_t3_rt_unused", 32'(StallD), 32'd0);
      chk("lit_t3_cnt", 32'(StallCycles), 32'd5);

      // 4: mult then mfhi, Done ten cycles later
      next(); MulDivStartD = 1'b1;
      #2 chk("lit_t4_mult", 32'(StallD), 32'd0);
      for (int i = 1; i <= 10; i++) begin
         next(); HiLoReadD = 1'b1; MulDivDone = (i == 10);
         #2 chk("lit_t4_wait", 32'(StallD), 32'd1);
      end
      next(); HiLoReadD = 1'b1;
      #2 chk("lit_t4_issue", 32'(StallD), 32'd0);
      chk("lit_t4_cnt", 32'(StallCycles), 32'd15);

      // 7: during the wait a load-to-branch gets one bubble, no STALL2
      next(); MulDivStartD = 1'b1;
      #2 chk("lit_t7_mult", 32'(StallD), 32'd0);
      next(); MemToRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd3;
      BranchD = 1'b1; RtD = 5'd3; UsesRtD = 1'b1;
      #2 chk("lit_t7_lu_br", 32'(StallD), 32'd1);
      next();
      #2 chk("lit_t7_no_stall2", 32'(StallD), 32'd0);
      next(); PCSrcD = 1'b1;
      #2 chk("lit_t7_flush", 32'(FlushD), 32'd1);
      next(); MulDivDone = 1'b1;
      #2 chk("lit_t7_done", 32'(StallD), 32'd0);
      next(); HiLoReadD = 1'b1;
      #2 chk("lit_t7_run", 32'(StallD), 32'd0);
      chk("lit_t7_cnt", 32'(StallCycles), 32'd16);

      // 5: mult/div never finishes -> timeout after 64 wait cycles
      next(); MulDivStartD = 1'b1;
      for (int i = 1; i <= MD_MAX; i++) begin
         next(); HiLoReadD = 1'b1;
         #2 chk("lit_t5_wait", 32'(StallD), 32'd1);
         chk("lit_t5_no_to", 32'(MdTimeout), 32'd0);
      end
      next(); HiLoReadD = 1'b1;
      #2 chk("lit_t5_drop", 32'(StallD), 32'd0);
      chk("lit_t5_to", 32'(MdTimeout), 32'd1);
      chk("lit_t5_cnt", 32'(StallCycles), 32'd80);

      // 6: reset in STALL2 and in MDWAIT
      next(); MemToRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd3;
      BranchD = 1'b1; RtD = 5'd3; UsesRtD = 1'b1;
      #2 chk("lit_t6_stall", 32'(StallD), 32'd1);
      next(); RESET = 1'b1; BranchD = 1'b1; PCSrcD = 1'b1;
      #2 chk("lit_t6_rst_stallf", 32'(StallF), 32'd0);
      chk("lit_t6_rst_flushe", 32'(FlushE), 32'd0);
      chk("lit_t6_rst_flushd", 32'(FlushD), 32'd0);
      next(); RESET = 1'b0;
      #2 chk("lit_t6_run", 32'(StallD), 32'd0);
      chk("lit_t6_cnt", 32'(StallCycles), 32'd0);
      chk("lit_t6_to", 32'(MdTimeout), 32'd0);
      next(); MulDivStartD = 1'b1;
      next(); HiLoReadD = 1'b1;
      #2 chk("lit_t6_md_stall", 32'(StallD), 32'd1);
      next(); HiLoReadD = 1'b1; RESET = 1'b1;
      #2 chk("lit_t6_md_rst", 32'(StallD), 32'd0);
      next(); RESET = 1'b0; HiLoReadD = 1'b1;
      #2 chk("lit_t6_md_run", 32'(StallD), 32'd0);
      chk("lit_t6_md_cnt", 32'(StallCycles), 32'd0);
      next();
      next();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
